// File: rtl/bubble_outbuf_loader.sv
// Loads a boot image or one page from a byte-wide image source into the bubble outbuffer,
// serialising each byte MSB first as a SETUP/STROBE write pair per bit.
module bubble_outbuf_loader (
   input  logic        MCLK,
   input  logic        nRESET,
   input  logic        START,
   input  logic        MODE,
   input  logic [10:0] PAGE,
   output logic        RD_REQ,
   output logic [19:0] RD_ADDR,
   input  logic        RD_ACK,
   input  logic [7:0]  RD_DATA,
   output logic [14:0] OUTBUFWADDR,
   output logic        OUTBUFWCLK,
   output logic        OUTBUFWDATA,
   output logic        BUSY,
   output logic        DONE,
   output logic        ERR
);

   localparam logic [8:0]  BootBytes   = 9'd480;
   localparam logic [8:0]  PageBytes   = 9'd128;
   localparam logic [14:0] BootBase    = 15'd4106;
   localparam logic [14:0] PageBase    = 15'd14342;
   localparam logic [19:0] PageOrigin  = 20'h00200;
   localparam logic [7:0]  TimeoutLast = 8'd254;

   typedef enum logic [2:0] {
      StIdle, StFetch, StSetup, StStrobe, StFinish, StFail
   } state_e;

   state_e      state_q;
   logic        mode_q;
   logic [10:0] page_q;
   logic [8:0]  byte_cnt_q;
   logic [11:0] gbit_q;
   logic [7:0]  tmo_q;
   logic [7:0]  data_q;

   logic [14:0] base;
   logic [8:0]  byte_total;
   logic [8:0]  byte_inc;
   logic [11:0] gbit_inc;

   assign base       = mode_q ? BootBase : PageBase;
   assign byte_total = mode_q ? BootBytes : PageBytes;
   assign byte_inc   = byte_cnt_q + 9'd1;
   assign gbit_inc   = gbit_q + 12'd1;

   function automatic logic [19:0] src_addr(input logic       mode,
                                            input logic [10:0] page,
                                            input logic [8:0]  idx);
      if (mode) begin
         return {11'd0, idx};
      end
      return PageOrigin + {2'b00, page, 7'd0} + {11'd0, idx};
   endfunction

   always_ff @(posedge MCLK or negedge nRESET) begin
      if (!nRESET) begin
         state_q     <= StIdle;
         mode_q      <= 1'b0;
         page_q      <= '0;
         byte_cnt_q  <= '0;
         gbit_q      <= '0;
         tmo_q       <= '0;
         data_q      <= '0;
         RD_REQ      <= 1'b0;
         RD_ADDR     <= '0;
         OUTBUFWADDR <= '0;
         OUTBUFWCLK  <= 1'b0;
         OUTBUFWDATA <= 1'b0;
         BUSY        <= 1'b0;
         DONE        <= 1'b0;
         ERR         <= 1'b0;
      end else begin
         DONE <= 1'b0;
         ERR  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (START) begin
                  mode_q     <= MODE;
                  page_q     <= PAGE;
                  byte_cnt_q <= '0;
                  gbit_q     <= '0;
                  tmo_q      <= '0;
                  RD_ADDR    <= src_addr(MODE, PAGE, 9'd0);
                  RD_REQ     <= 1'b1;
                  BUSY       <= 1'b1;
                  state_q    <= StFetch;
               end
            end
            StFetch: begin
               if (RD_ACK) begin
                  data_q      <= RD_DATA;
                  RD_REQ      <= 1'b0;
                  OUTBUFWADDR <= base + {3'b000, gbit_q};
                  OUTBUFWDATA <= RD_DATA[7];
                  state_q     <= StSetup;
               end else if (tmo_q == TimeoutLast) begin
                  // 255th FETCH cycle without an ack
                  RD_REQ  <= 1'b0;
                  ERR     <= 1'b1;
                  state_q <= StFail;
               end else begin
                  tmo_q <= tmo_q + 8'd1;
               end
            end
            StSetup: begin
               OUTBUFWCLK <= 1'b1;
               state_q    <= StStrobe;
            end
            StStrobe: begin
               OUTBUFWCLK <= 1'b0;
               gbit_q     <= gbit_inc;
               // Bytes start on multiples of 8, so the low index bits give the bit-in-byte
               if (gbit_q[2:0] == 3'd7) begin
                  byte_cnt_q <= byte_inc;
                  if (byte_inc == byte_total) begin
                     DONE    <= 1'b1;
                     state_q <= StFinish;
                  end else begin
                     RD_ADDR <= src_addr(mode_q, page_q, byte_inc);
                     RD_REQ  <= 1'b1;
                     tmo_q   <= '0;
                     state_q <= StFetch;
                  end
               end else begin
                  data_q      <= {data_q[6:0], 1'b0};
                  OUTBUFWDATA <= data_q[6];
                  OUTBUFWADDR <= base + {3'b000, gbit_inc};
                  state_q     <= StSetup;
               end
            end
            StFinish: begin
               BUSY    <= 1'b0;
               state_q <= StIdle;
            end
            StFail: begin
               BUSY    <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bubble_outbuf_loader.sv
// Randomized directed bench for bubble_outbuf_loader: an image-source responder, an outbuffer
// monitor and a reference model that derives the expected write stream from the load rules.
module tb_bubble_outbuf_loader;

   logic        MCLK = 1'b0;
   logic        nRESET;
   logic        START;
   logic        MODE;
   logic [10:0] PAGE;
   logic        RD_REQ;
   logic [19:0] RD_ADDR;
   logic        RD_ACK;
   logic [7:0]  RD_DATA;
   logic [14:0] OUTBUFWADDR;
   logic        OUTBUFWCLK;
   logic        OUTBUFWDATA;
   logic        BUSY;
   logic        DONE;
   logic        ERR;

   bubble_outbuf_loader dut (
      .MCLK        (MCLK),
      .nRESET      (nRESET),
      .START       (START),
      .MODE        (MODE),
      .PAGE        (PAGE),
      .RD_REQ      (RD_REQ),
      .RD_ADDR     (RD_ADDR),
      .RD_ACK      (RD_ACK),
      .RD_DATA     (RD_DATA),
      .OUTBUFWADDR (OUTBUFWADDR),
      .OUTBUFWCLK  (OUTBUFWCLK),
      .OUTBUFWDATA (OUTBUFWDATA),
      .BUSY        (BUSY),
      .DONE        (DONE),
      .ERR         (ERR)
   );

   always #10 MCLK = ~MCLK;

   int n_checks = 0;
   int n_errors = 0;

   // Source image behaviour
   logic [7:0]  seed = 8'h00;
   bit          fixed_en = 1'b0;
   logic [7:0]  fixed_val = 8'h00;
   bit          ack_always = 1'b0;
   int          lat_fixed = -1;
   logic [19:0] hold_addr = 20'hFFFFF;

   // Monitor observations
   logic [14:0] wr_addr_q[$];
   logic        wr_data_q[$];
   logic [19:0] rd_addr_q[$];
   int  done_cnt, err_cnt, busy_low, req_run, last_run, cyc, last_strobe_cyc, done_cyc;
   bit  ended, load_active;

   function automatic logic [7:0] src_byte(input logic [19:0] a);
      logic [19:0] t;
      if (fixed_en) return fixed_val;
      t = a * 20'd37;
      return t[7:0] ^ t[15:8] ^ seed;
   endfunction

   function automatic int exp_rd(input logic mode, input logic [10:0] page, input int i);
      return mode ? i : 512 + int'(page) * 128 + i;
   endfunction

   task automatic check_int(input string tag, input int got, input int exp);
      n_checks++;
      assert (got === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // Image source: acks each request after a per-request latency
   initial begin
      int  wait_cnt;
      int  cur_lat;
      bit  req_prev;
      RD_ACK   = 1'b0;
      RD_DATA  = 8'h00;
      wait_cnt = 0;
      cur_lat  = 0;
      req_prev = 1'b0;
      forever begin
         @(negedge MCLK);
         if (ack_always) begin
            RD_ACK  = 1'b1;
            RD_DATA = src_byte(RD_ADDR);
         end else if (RD_REQ === 1'b1) begin
            if (!req_prev) begin
               wait_cnt = 0;
               cur_lat  = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
            end
            if (RD_ADDR !== hold_addr && wait_cnt >= cur_lat) begin
               RD_ACK  = 1'b1;
               RD_DATA = src_byte(RD_ADDR);
            end else begin
               RD_ACK  = 1'b0;
               RD_DATA = 8'($urandom);
            end
            wait_cnt++;
         end else begin
            RD_ACK = 1'b0;
         end
         req_prev = (RD_REQ === 1'b1);
      end
   end

   // Outbuffer / request monitor, including the strobe-shape rule on every write
   initial begin
      logic        prev_wclk;
      logic [14:0] prev_addr;
      logic        prev_data;
      bit          prev_req;
      prev_wclk = 1'b0;
      prev_addr = '0;
      prev_data = 1'b0;
      prev_req  = 1'b0;
      cyc       = 0;
      forever begin
         @(negedge MCLK);
         cyc++;
         if (OUTBUFWCLK === 1'b1) begin
            wr_addr_q.push_back(OUTBUFWADDR);
            wr_data_q.push_back(OUTBUFWDATA);
            last_strobe_cyc = cyc;
            n_checks++;
            assert (prev_wclk === 1'b0 && OUTBUFWADDR === prev_addr && OUTBUFWDATA === prev_data)
            else begin
               n_errors++;
               $error("FAIL strobe_shape: observed wclk_prev=%b addr=%0d/%0d data=%b/%b expected 0 and stable",
                      prev_wclk, prev_addr, OUTBUFWADDR, prev_data, OUTBUFWDATA);
            end
         end
         if (RD_REQ === 1'b1) begin
            if (!prev_req) rd_addr_q.push_back(RD_ADDR);
            req_run++;
         end else begin
            if (prev_req) last_run = req_run;
            req_run = 0;
         end
         if (DONE === 1'b1) begin
            done_cnt++;
            done_cyc    = cyc;
            ended       = 1'b1;
            load_active = 1'b0;
         end
         if (ERR === 1'b1) begin
            err_cnt++;
            ended       = 1'b1;
            load_active = 1'b0;
         end
         if (load_active && BUSY !== 1'b1) busy_low++;
         prev_wclk = OUTBUFWCLK;
         prev_addr = OUTBUFWADDR;
         prev_data = OUTBUFWDATA;
         prev_req  = (RD_REQ === 1'b1);
      end
   end

   task automatic clear_stats();
      wr_addr_q.delete();
      wr_data_q.delete();
      rd_addr_q.delete();
      done_cnt = 0; err_cnt = 0; busy_low = 0; req_run = 0; last_run = 0;
      last_strobe_cyc = 0; done_cyc = 0; ended = 1'b0;
   endtask

   task automatic start_pulse(input logic mode, input logic [10:0] page);
      @(negedge MCLK); #1;
      START = 1'b1; MODE = mode; PAGE = page;
      @(negedge MCLK); #1;
      START = 1'b0; MODE = 1'($urandom); PAGE = 11'($urandom);
      load_active = 1'b1;
   endtask

   task automatic wait_end(input string tag, input int bound);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < bound; c++) begin
         @(negedge MCLK); #1;
         if (ended) begin
            ok = 1'b1;
            break;
         end
      end
      check_int({tag, " completion_within_bound"}, int'(ok), 1);
      repeat (2) @(negedge MCLK);
      #1;
   endtask

   // Compare observed writes and requests against the load rules
   task automatic check_load(input string tag, input logic mode, input logic [10:0] page,
                             input int nbytes, input int nreq);
      int         bad;
      int         exp_a;
      logic [7:0] b;
      check_int({tag, " strobe_count"}, wr_addr_q.size(), nbytes * 8);
      bad = -1;
      for (int i = 0; i < nbytes * 8 && i < wr_addr_q.size(); i++) begin
         exp_a = (mode ? 4106 : 14342) + i;
         b     = src_byte(20'(exp_rd(mode, page, i / 8)));
         if (bad < 0 && (int'(wr_addr_q[i]) != exp_a || wr_data_q[i] !== b[7 - (i % 8)])) bad = i;
      end
      check_int({tag, " first_bad_write_index"}, bad, -1);
      check_int({tag, " request_count"}, rd_addr_q.size(), nreq);
      bad = -1;
      for (int j = 0; j < nreq && j < rd_addr_q.size(); j++) begin
         if (bad < 0 && int'(rd_addr_q[j]) != exp_rd(mode, page, j)) bad = j;
      end
      check_int({tag, " first_bad_request_index"}, bad, -1);
   endtask

   initial begin
      logic [10:0] p1;
      logic [10:0] p2;
      logic [7:0]  pat;
      int          bits;
      START = 1'b0; MODE = 1'b0; PAGE = '0;
      load_active = 1'b0;
      clear_stats();

      // Reset values
      nRESET = 1'b0;
      repeat (3) @(negedge MCLK);
      #1;
      check_int("rst RD_REQ", int'(RD_REQ), 0);
      check_int("rst RD_ADDR", int'(RD_ADDR), 0);
      check_int("rst OUTBUFWADDR", int'(OUTBUFWADDR), 0);
      check_int("rst OUTBUFWCLK", int'(OUTBUFWCLK), 0);
      check_int("rst OUTBUFWDATA", int'(OUTBUFWDATA), 0);
      check_int("rst BUSY", int'(BUSY), 0);
      check_int("rst DONE", int'(DONE), 0);
      check_int("rst ERR", int'(ERR), 0);
      nRESET = 1'b1;
      repeat (2) @(negedge MCLK);

      // Page 3, data 0xA5, ack one cycle after request
      clear_stats();
      fixed_en = 1'b1; fixed_val = 8'hA5; lat_fixed = 1;
      start_pulse(1'b0, 11'd3);
      wait_end("page3", 5000);
      check_load("page3", 1'b0, 11'd3, 128, 128);
      pat  = 8'hA5;
      bits = 0;
      for (int k = 0; k < 8 && k < wr_data_q.size(); k++) bits = bits * 2 + int'(wr_data_q[k]);
      check_int("page3 first_byte_bits", bits, int'(pat));
      check_int("page3 first_addr", (wr_addr_q.size() > 0) ? int'(wr_addr_q[0]) : -1, 14342);
      check_int("page3 done_pulses", done_cnt, 1);
      check_int("page3 err_pulses", err_cnt, 0);
      check_int("page3 busy_after", int'(BUSY), 0);

      // Boot load with RD_ACK held high everywhere
      clear_stats();
      fixed_en = 1'b0; seed = 8'($urandom); ack_always = 1'b1;
      start_pulse(1'b1, 11'($urandom));
      wait_end("boot", 20000);
      ack_always = 1'b0;
      check_load("boot", 1'b1, 11'd0, 480, 480);
      check_int("boot last_addr", (wr_addr_q.size() > 0) ? int'(wr_addr_q[$]) : -1, 7945);
      check_int("boot busy_low_cycles", busy_low, 0);
      check_int("boot done_pulses", done_cnt, 1);
      check_int("boot done_after_last_strobe", int'(done_cyc > last_strobe_cyc), 1);

      // Byte 5 never acknowledged
      clear_stats();
      seed = 8'($urandom); lat_fixed = -1;
      p1 = 11'($urandom);
      hold_addr = 20'(exp_rd(1'b0, p1, 5));
      start_pulse(1'b0, p1);
      wait_end("timeout", 5000);
      hold_addr = 20'hFFFFF;
      check_load("timeout", 1'b0, p1, 5, 6);
      check_int("timeout fetch_cycles", last_run, 255);
      check_int("timeout err_pulses", err_cnt, 1);
      check_int("timeout done_pulses", done_cnt, 0);
      check_int("timeout busy_after", int'(BUSY), 0);

      // Second START mid-load is ignored
      clear_stats();
      seed = 8'($urandom);
      p1 = 11'($urandom);
      p2 = p1 ^ 11'h2A5;
      start_pulse(1'b0, p1);
      repeat (100) @(negedge MCLK);
      start_pulse(1'b1, p2);
      wait_end("restart_ignored", 5000);
      check_load("restart_ignored", 1'b0, p1, 128, 128);
      check_int("restart_ignored done_pulses", done_cnt, 1);

      // Reset during a strobe, then a clean load
      clear_stats();
      start_pulse(1'b0, 11'($urandom));
      for (int c = 0; c < 200; c++) begin
         @(negedge MCLK); #1;
         if (OUTBUFWCLK === 1'b1) break;
      end
      check_int("midrst strobe_reached", int'(OUTBUFWCLK), 1);
      nRESET = 1'b0;
      load_active = 1'b0;
      #1;
      check_int("midrst OUTBUFWCLK", int'(OUTBUFWCLK), 0);
      check_int("midrst BUSY", int'(BUSY), 0);
      check_int("midrst RD_REQ", int'(RD_REQ), 0);
      check_int("midrst OUTBUFWADDR", int'(OUTBUFWADDR), 0);
      repeat (3) @(negedge MCLK);
      #1;
      nRESET = 1'b1;
      @(negedge MCLK); #1;
      check_int("midrst idle_after_release", int'(BUSY), 0);
      check_int("midrst done_pulses", done_cnt, 0);
      check_int("midrst err_pulses", err_cnt, 0);
      clear_stats();
      seed = 8'($urandom);
      p1 = 11'($urandom);
      start_pulse(1'b0, p1);
      wait_end("after_rst", 5000);
      check_load("after_rst", 1'b0, p1, 128, 128);
      check_int("after_rst done_pulses", done_cnt, 1);

      // Random page loads with random latency
      for (int n = 0; n < 2; n++) begin
         clear_stats();
         seed = 8'($urandom);
         p1 = 11'($urandom);
         start_pulse(1'b0, p1);
         wait_end("rand_page", 5000);
         check_load("rand_page", 1'b0, p1, 128, 128);
         check_int("rand_page done_pulses", done_cnt, 1);
         check_int("rand_page busy_low_cycles", busy_low, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bubble_outbuf_loader.md
BUBBLE_OUTBUF_LOADER -- requirements
Module: bubble_outbuf_loader

Interface
REQ-001 SHALL have port MCLK, input, 1 bit: 48 MHz system clock; all state changes on its rising edge.
REQ-002 SHALL have port nRESET, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port START, input, 1 bit: one-cycle load request.
REQ-004 SHALL have port MODE, input, 1 bit: 0 = page load, 1 = bootloader load.
REQ-005 SHALL have port PAGE, input, 11 bits: page number, sampled with START.
REQ-006 SHALL have port RD_REQ, output, 1 bit: byte fetch request to the image source.
REQ-007 SHALL have port RD_ADDR, output, 20 bits: source byte address.
REQ-008 SHALL have port RD_ACK, input, 1 bit: source data valid.
REQ-009 SHALL have port RD_DATA, input, 8 bits: source byte.
REQ-010 SHALL have port OUTBUFWADDR, output, 15 bits: outbuffer write address; bit 0 selects channel (0 = DOUT0, 1 = DOUT1).
REQ-011 SHALL have port OUTBUFWCLK, output, 1 bit: outbuffer write strobe.
REQ-012 SHALL have port OUTBUFWDATA, output, 1 bit: outbuffer write bit.
REQ-013 SHALL have port BUSY, output, 1 bit: load in progress.
REQ-014 SHALL have port DONE, output, 1 bit: one-cycle pulse on successful completion.
REQ-015 SHALL have port ERR, output, 1 bit: one-cycle pulse on fetch timeout.

Function
REQ-016 SHALL use states IDLE, FETCH, SETUP, STROBE, FINISH, FAIL.
REQ-017 SHALL, in IDLE with START=1, latch MODE/PAGE, clear byte and bit counters, and enter FETCH next cycle; START outside IDLE SHALL be ignored.
REQ-018 SHALL drive the byte count: boot = 480 bytes at RD_ADDR 0..479; page = 128 bytes at RD_ADDR 0x00200 + PAGE*128 + i.
REQ-019 SHALL set the write base: boot = 4106 (position 2053, channel 0); page = 14342 (position 7171, channel 0).
REQ-020 SHALL hold RD_REQ=1 throughout FETCH; on sampling RD_ACK=1, SHALL capture RD_DATA, drop RD_REQ, and enter SETUP next cycle.
REQ-021 SHALL count FETCH cycles with an 8-bit counter; at 255 cycles without RD_ACK, SHALL enter FAIL.
REQ-022 SHALL serialise each byte MSB first, one bit per SETUP/STROBE pair.
REQ-023 SHALL, in SETUP, present OUTBUFWADDR = base + global bit index and OUTBUFWDATA = current bit, with OUTBUFWCLK=0.
REQ-024 SHALL, in STROBE, hold address and data unchanged with OUTBUFWCLK=1.
REQ-025 SHALL time each bit at exactly 2 cycles, giving 16 cycles per byte plus fetch latency.
REQ-026 SHALL, after STROBE of bit 7: enter FETCH when bytes remain, otherwise FINISH.
REQ-027 SHALL make the last addresses 7945 (boot) and 15365 (page).
REQ-028 SHALL assert DONE for one cycle in FINISH, then return to IDLE.
REQ-029 SHALL assert ERR for one cycle in FAIL, then return to IDLE; the partial buffer is not restored.
REQ-030 SHALL assert BUSY=1 in every state except IDLE.
REQ-031 SHALL take the global bit index from a 12-bit counter (max 3839) and perform the address addition at 15-bit width without wrap.
REQ-032 SHALL ignore RD_ACK outside FETCH.
REQ-033 SHALL, when RD_ACK is already high on FETCH entry, accept it in that first FETCH cycle.

Reset
REQ-034 SHALL, while nRESET=0, asynchronously force state IDLE and all counters to 0.
REQ-035 SHALL, while nRESET=0, force RD_REQ=0, OUTBUFWCLK=0, BUSY=0, DONE=0, ERR=0, OUTBUFWADDR=0, OUTBUFWDATA=0, RD_ADDR=0.
REQ-036 SHALL, when reset is asserted mid-load, abandon the load with no DONE/ERR pulse; the first cycle after release is IDLE.

Verification
REQ-037 Page load, PAGE=3, ack 1 cycle after request, data 0xA5 -> RD_ADDR 0x00380..0x003FF; first writes at 14342..14349 = 1,0,1,0,0,1,0,1; DONE once; 128*8 strobes.
REQ-038 Boot load, zero-latency ack -> 3840 strobes at addresses 4106..7945; BUSY high throughout; DONE once after the last strobe.
REQ-039 RD_ACK withheld on byte 5 -> ERR pulse after 255 FETCH cycles; exactly 40 strobes issued; IDLE, BUSY=0.
REQ-040 START pulsed again mid-load with a different PAGE -> ignored; addresses follow the first PAGE only.
REQ-041 nRESET low during STROBE -> OUTBUFWCLK=0 immediately; no DONE; a new START after release completes normally.
REQ-042 Strobe-shape check on every bit -> OUTBUFWADDR/OUTBUFWDATA stable one cycle before and during OUTBUFWCLK=1; OUTBUFWCLK never high two consecutive cycles.
